// File: rtl/imem_loader_if.sv
// Host-side byte stream, start/length command and inst_memory write port of imem_loader.
// master = image source / memory side, slave = the loader.
interface imem_loader_if #(
    parameter int unsigned LEN_W = 16
);
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_byte_valid;
    logic [7:0]       i_byte_data;
    logic             o_byte_ready;
    logic             o_mem_we;
    logic [31:0]      o_mem_addr;
    logic [31:0]      o_mem_wdata;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic             o_cpu_rstn;

    modport master (
        output i_start, i_len, i_byte_valid, i_byte_data,
        input  o_byte_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_busy, o_done, o_err, o_cpu_rstn
    );

    modport slave (
        input  i_start, i_len, i_byte_valid, i_byte_data,
        output o_byte_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_busy, o_done, o_err, o_cpu_rstn
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit inst_memory writes and holds the CPU in reset
// until the image is loaded. Define IMEM_LOADER_CHKSUM_EN to require a trailing checksum byte.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned LEN_W       = 16
) (
    input logic          i_clk,
    input logic          i_rst,
    imem_loader_if.slave bus
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS) + 1;

`ifdef IMEM_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StChk} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;
`endif

    state_e           state_q;
    logic [IdxW-1:0]  word_idx_q;
    logic [1:0]       byte_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             ready_q, we_q, busy_q, done_q, err_q, cpu_rstn_q;
    logic [31:0]      addr_q, wdata_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]       sum_q;
    logic             chk_ok;
    assign chk_ok = (8'(sum_q + bus.i_byte_data) == 8'h00);
`endif

    logic [IdxW-1:0] idx_inc;
    logic            len_last;
    logic            xfer;
    assign idx_inc  = word_idx_q + IdxW'(1);
    assign len_last = (32'(idx_inc) == 32'(len_q));
    assign xfer     = bus.i_byte_valid && ready_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rstn_q <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.i_start) begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        len_q  <= bus.i_len;
                        if (bus.i_len == '0) begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            cpu_rstn_q <= 1'b1;
                        end else if (32'(bus.i_len) > DEPTH_WORDS) begin
                            state_q    <= StIdle;
                            err_q      <= 1'b1;
                            cpu_rstn_q <= 1'b0;
                        end else begin
                            state_q    <= StRecv;
                            busy_q     <= 1'b1;
                            ready_q    <= 1'b1;
                            cpu_rstn_q <= 1'b0;
                            word_idx_q <= '0;
                            byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                            sum_q      <= '0;
`endif
                        end
                    end
                end
                StRecv: begin
                    if (xfer) begin
                        wdata_q[{byte_cnt_q, 3'b000} +: 8] <= bus.i_byte_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                        sum_q      <= sum_q + bus.i_byte_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= StWrite;
                            ready_q <= 1'b0;
                            we_q    <= 1'b1;
                            addr_q  <= BASE_ADDR + (32'(word_idx_q) << 2);
                        end
                    end
                end
                StWrite: begin
                    we_q       <= 1'b0;
                    word_idx_q <= idx_inc;
                    byte_cnt_q <= '0;
                    if (len_last) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        state_q    <= StChk;
                        ready_q    <= 1'b1;
`else
                        state_q    <= StDone;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_rstn_q <= 1'b1;
`endif
                    end else begin
                        state_q <= StRecv;
                        ready_q <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                StChk: begin
                    // Single checksum byte: image bytes plus checksum must sum to zero mod 256.
                    if (xfer) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        if (chk_ok) begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            cpu_rstn_q <= 1'b1;
                        end else begin
                            state_q    <= StIdle;
                            err_q      <= 1'b1;
                            cpu_rstn_q <= 1'b0;
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_byte_ready = ready_q;
    assign bus.o_mem_we     = we_q;
    assign bus.o_mem_addr   = addr_q;
    assign bus.o_mem_wdata  = wdata_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_err        = err_q;
    assign bus.o_cpu_rstn   = cpu_rstn_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized images checked
// against a byte-queue model of the expected word writes.
module tb_imem_loader;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   overlap = 0;
    logic [7:0] img[$];

    imem_loader_if #(.LEN_W(16)) bus ();

    imem_loader #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LEN_W      (16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_mem_we === 1'b1) wr_cnt <= wr_cnt + 1;
        if (bus.o_mem_we === 1'b1 && bus.o_byte_ready === 1'b1) overlap <= overlap + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_ready"}, 32'(bus.o_byte_ready), 0);
        check({p, "_we"}, 32'(bus.o_mem_we), 0);
        check({p, "_addr"}, bus.o_mem_addr, BASE);
        check({p, "_wdata"}, bus.o_mem_wdata, 0);
        check({p, "_busy"}, 32'(bus.o_busy), 0);
        check({p, "_done"}, 32'(bus.o_done), 0);
        check({p, "_err"}, 32'(bus.o_err), 0);
        check({p, "_cpu_rstn"}, 32'(bus.o_cpu_rstn), 0);
    endtask

    task automatic fill_random(input int words);
        img.delete();
        for (int i = 0; i < 4 * words; i++) img.push_back(8'($urandom));
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_len   = 16'(len);
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.i_byte_valid = 1'b1;
        bus.i_byte_data  = b;
        while (bus.o_byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 100), 1);
        @(posedge clk);
        #1 bus.i_byte_valid = 1'b0;
    endtask

    // Model: word w is img[4w..4w+3] little-endian, written at BASE + 4w.
    task automatic run_load(input int len, input int gmin, input int gmax, input bit bad_sum,
                            input int poke);
        int         base_wr, n;
        logic [7:0] sum;
        logic [31:0] word;
        bit         ok;
        base_wr = wr_cnt;
        sum     = 8'h00;
        ok      = 1'b1;
        pulse_start(len);
        if (len > int'(DEPTH)) begin
            check("ovr_err", 32'(bus.o_err), 1);
            check("ovr_ready", 32'(bus.o_byte_ready), 0);
            check("ovr_cpu_rstn", 32'(bus.o_cpu_rstn), 0);
            check("ovr_busy", 32'(bus.o_busy), 0);
            repeat (3) @(negedge clk);
            check("ovr_no_we", 32'(wr_cnt - base_wr), 0);
            return;
        end
        if (len == 0) begin
            check("zero_done", 32'(bus.o_done), 1);
            check("zero_cpu_rstn", 32'(bus.o_cpu_rstn), 1);
            check("zero_busy", 32'(bus.o_busy), 0);
            repeat (3) @(negedge clk);
            check("zero_no_we", 32'(wr_cnt - base_wr), 0);
            return;
        end
        check("start_busy", 32'(bus.o_busy), 1);
        check("start_done", 32'(bus.o_done), 0);
        check("start_cpu_rstn", 32'(bus.o_cpu_rstn), 0);
        check("start_ready", 32'(bus.o_byte_ready), 1);
        for (int w = 0; w < len; w++) begin
            for (int k = 0; k < 4; k++) begin
                sum += img[4 * w + k];
                send_byte(img[4 * w + k], $urandom_range(gmax, gmin));
                if (4 * w + k == poke) pulse_start(0);
            end
            word = {img[4 * w + 3], img[4 * w + 2], img[4 * w + 1], img[4 * w]};
            @(negedge clk);
            check("wr_we", 32'(bus.o_mem_we), 1);
            check("wr_addr", bus.o_mem_addr, BASE + 32'(4 * w));
            check("wr_data", bus.o_mem_wdata, word);
            check("wr_ready", 32'(bus.o_byte_ready), 0);
            check("wr_cpu_rstn", 32'(bus.o_cpu_rstn), 0);
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        ok = !bad_sum;
        send_byte(bad_sum ? 8'(8'h01 - sum) : 8'(8'h00 - sum), gmin);
`endif
        n = 0;
        while (!(bus.o_done === 1'b1 || bus.o_err === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("end_timeout", 32'(n < 50), 1);
        @(negedge clk);
        check("end_done", 32'(bus.o_done), 32'(ok));
        check("end_err", 32'(bus.o_err), 32'(!ok));
        check("end_cpu_rstn", 32'(bus.o_cpu_rstn), 32'(ok));
        check("end_busy", 32'(bus.o_busy), 0);
        check("end_ready", 32'(bus.o_byte_ready), 0);
        check("end_wr_count", 32'(wr_cnt - base_wr), 32'(len));
    endtask

    initial begin
        bus.i_start      = 1'b0;
        bus.i_len        = '0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte_data  = '0;

        #3 check_reset("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("idle");

        // Two-instruction image: addi x0 / addi x1,x0,1.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, 0, 0, 1'b0, -1);
        repeat (5) @(negedge clk);
        check("done_holds", 32'(bus.o_done), 1);
        check("done_cpu_holds", 32'(bus.o_cpu_rstn), 1);

        // Valid toggles every other cycle; ready must never overlap a write.
        fill_random(1);
        run_load(1, 1, 1, 1'b0, -1);
        check("ready_we_overlap", 32'(overlap), 0);

        run_load(257, 0, 0, 1'b0, -1);
        run_load(0, 0, 0, 1'b0, -1);

        // Reset after the 2nd byte of word 1.
        fill_random(3);
        pulse_start(3);
        for (int k = 0; k < 4; k++) send_byte(img[k], 0);
        @(negedge clk);
        send_byte(img[4], 0);
        send_byte(img[5], 0);
        #1 rst = 1'b1;
        #1 check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        fill_random(1);
        run_load(1, 0, 1, 1'b0, -1);

        // Restart from DONE; a start pulse mid-load must be ignored.
        fill_random(1);
        run_load(1, 0, 2, 1'b0, 1);

        for (int it = 0; it < 6; it++) begin
            fill_random(int'($urandom_range(6, 1)));
            run_load(img.size() / 4, 0, 3, 1'b0, -1);
        end

        fill_random(int'(DEPTH));
        run_load(int'(DEPTH), 0, 0, 1'b0, -1);

`ifdef IMEM_LOADER_CHKSUM_EN
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 0, 1'b0, -1);
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 0, 1'b1, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
